// File: rtl/keypad_ctrl.sv
// 4x4 active-low keypad scanner with full-matrix debounce and a move-pulse FSM.
// Emits single-cycle paddle move codes with auto-repeat while a mapped key is held.
module keypad_ctrl #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] control,
  output logic [3:0] key_stable,
  output logic       scan_done
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MATCH_W = $clog2(DEBOUNCE + 1);
  localparam int REP_W   = $clog2(REPEAT + 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [1:0]         row_q, row_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        snap_q, snap_d;
  logic               full_q, full_d;
  logic               scan_done_q, scan_done_d;
  logic [15:0]        prev_q, prev_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [15:0]        stable_q, stable_d;
  state_t             state_q, state_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [3:0]         control_q, control_d;
  logic [3:0]         key_prev_q, key_prev_d;

  logic [3:0] key_idx;
  logic [3:0] new_code;
  logic       key_change;

  function automatic logic [3:0] decode_key(input logic [15:0] snap);
    logic [4:0] ones;
    logic [3:0] idx;
    ones = '0;
    idx  = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    return (ones == 5'd1) ? idx : 4'hF;
  endfunction

  function automatic logic [3:0] move_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0100;
      4'd1:    return 4'b0001;
      4'd4:    return 4'b0110;
      4'd5:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Row scan: sample the driven row just before moving on to the next one.
  always_comb begin
    row_d  = row_q;
    div_d  = div_q + DIV_W'(1);
    snap_d = snap_q;
    full_d = 1'b0;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d                        = '0;
      snap_d[{row_q, 2'b00} +: 4]  = ~keypad_col;
      row_d                        = row_q + 2'd1;
      full_d                       = (row_q == 2'd3);
    end
  end

  // Debounce runs one clock after the last row capture, alongside scan_done.
  always_comb begin
    scan_done_d = full_q;
    prev_d      = prev_q;
    match_d     = match_q;
    stable_d    = stable_q;
    if (full_q) begin
      if (snap_q == prev_q) begin
        if (match_q != MATCH_W'(DEBOUNCE)) match_d = match_q + MATCH_W'(1);
      end else begin
        match_d = MATCH_W'(1);
        prev_d  = snap_q;
      end
      if (match_d == MATCH_W'(DEBOUNCE)) stable_d = snap_q;
    end
  end

  assign key_idx    = decode_key(stable_q);
  assign new_code   = move_code(key_idx);
  assign key_change = (key_idx != key_prev_q);

  // A stable-key change takes priority over a coinciding repeat tick.
  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    control_d  = 4'b1111;
    key_prev_d = key_idx;
    case (state_q)
      IDLE: begin
        if (key_change && (new_code != 4'b1111)) begin
          control_d = new_code;
          rep_d     = '0;
          state_d   = HELD;
        end
      end
      HELD: begin
        if (key_change) begin
          rep_d = '0;
          if (new_code != 4'b1111) control_d = new_code;
          else                     state_d   = IDLE;
        end else if (scan_done_q) begin
          if (rep_q == REP_W'(REPEAT - 1)) begin
            control_d = new_code;
            rep_d     = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q       <= '0;
      div_q       <= '0;
      snap_q      <= '0;
      full_q      <= 1'b0;
      scan_done_q <= 1'b0;
      prev_q      <= '0;
      match_q     <= '0;
      stable_q    <= '0;
      state_q     <= IDLE;
      rep_q       <= '0;
      control_q   <= 4'b1111;
      key_prev_q  <= 4'hF;
    end else begin
      row_q       <= row_d;
      div_q       <= div_d;
      snap_q      <= snap_d;
      full_q      <= full_d;
      scan_done_q <= scan_done_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      rep_q       <= rep_d;
      control_q   <= control_d;
      key_prev_q  <= key_prev_d;
    end
  end

  assign keypad_row = ~(4'b0001 << row_q);
  assign control    = control_q;
  assign key_stable = key_idx;
  assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: a key-matrix model drives the columns, and a timing
// model queues every expected move pulse for comparison as control produces it.
module tb_keypad_ctrl;
  localparam int SCAN_DIV = 16;
  localparam int DEBOUNCE = 4;
  localparam int REPEAT   = 8;
  localparam int SCAN     = 4 * SCAN_DIV;
  localparam int RPT      = REPEAT * SCAN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  keypad_col;
  logic [3:0]  keypad_row;
  logic [3:0]  control;
  logic [3:0]  key_stable;
  logic        scan_done;
  logic [15:0] pressed = '0;
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } pulse_t;

  typedef struct {
    logic [15:0] mask;
    int          scans;
    logic [3:0]  exp_key;
  } vec_t;

  pulse_t exp_q[$];

  bit          m_fresh;
  bit          m_held;
  logic [3:0]  m_idx;
  logic [3:0]  m_code;
  int          m_next_rep;
  logic [15:0] m_last_mask;
  int          m_streak;

  keypad_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .keypad_col (keypad_col),
    .keypad_row (keypad_row),
    .control    (control),
    .key_stable (key_stable),
    .scan_done  (scan_done)
  );

  always #5 clock = ~clock;

  // Closed keys pull their column low only while their row is driven.
  always_comb begin
    keypad_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!keypad_row[r]) keypad_col = keypad_col & ~pressed[4*r +: 4];
  end

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] expected_key(input logic [15:0] m);
    if ($countones(m) != 1) return 4'hF;
    for (int i = 0; i < 16; i++)
      if (m[i]) return 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [3:0] expected_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0100;
      4'd1:    return 4'b0001;
      4'd4:    return 4'b0110;
      4'd5:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic push_pulse(input logic [3:0] code, input int at);
    pulse_t p;
    p.code = code;
    p.at   = at;
    exp_q.push_back(p);
  endtask

  task automatic push_repeats(input int limit);
    while (m_held && m_next_rep <= limit) begin
      push_pulse(m_code, m_next_rep);
      m_next_rep += RPT;
    end
  endtask

  task automatic wait_cycle(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != target) check_output("wait_cycle", cyc, target);
  endtask

  task automatic model_reset();
    m_fresh = 1'b1;
    m_held  = 1'b0;
    m_idx   = 4'hF;
    exp_q.delete();
  endtask

  // Called right after a scan boundary; the new pattern is seen by the whole next scan.
  task automatic apply_stimulus(input logic [15:0] mask, input int scans);
    int         s;
    int         e;
    int         t;
    logic [3:0] idx;
    s = cyc;
    e = s + scans * SCAN;
    if (m_fresh || mask != m_last_mask) m_streak = s;
    m_fresh     = 1'b0;
    m_last_mask = mask;
    pressed     = mask;
    t   = m_streak + DEBOUNCE * SCAN;
    idx = expected_key(mask);
    if (t > s && t <= e && idx != m_idx) begin
      push_repeats(t);
      m_idx = idx;
      if (expected_code(idx) != 4'b1111) begin
        m_held     = 1'b1;
        m_code     = expected_code(idx);
        push_pulse(m_code, t + 1);
        m_next_rep = t + 1 + RPT;
      end else begin
        m_held = 1'b0;
      end
    end
    push_repeats(e);
    wait_cycle(e);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_row"},        keypad_row, 4'b1110);
    check_output({tag, "_control"},    control,    4'b1111);
    check_output({tag, "_key_stable"}, key_stable, 4'hF);
    check_output({tag, "_scan_done"},  scan_done,  1'b0);
  endtask

  // Per-cycle checks of row drive, scan_done timing and the pulse scoreboard.
  always @(negedge clock) begin : monitor
    pulse_t     e;
    logic [3:0] row_exp;
    if (reset) begin
      row_exp = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      check_output("keypad_row", keypad_row, row_exp);
      check_output("scan_done", scan_done, (cyc >= SCAN + 1) && (cyc % SCAN == 1));
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        check_output("pulse_missing_at", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (control !== 4'b1111) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_pulse", control, 4'b1111);
        end else begin
          e = exp_q.pop_front();
          check_output("pulse_code", control, e.code);
          check_output("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs = '{
      '{16'h0002, 6, 4'h1},
      '{16'h0000, 6, 4'hF},
      '{16'h0001, 6, 4'h0},
      '{16'h0010, 6, 4'h4},
      '{16'h0020, 6, 4'h5},
      '{16'h0030, 6, 4'hF},
      '{16'h0400, 6, 4'hA},
      '{16'h8000, 6, 4'hF},
      '{16'h0003, 6, 4'hF},
      '{16'h0000, 6, 4'hF}
    };

    reset   = 1'b0;
    pressed = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values("power_on");
    reset = 1'b1;
    wait_cycle(1);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].mask, vecs[i].scans);
      check_output($sformatf("vec%0d_key_stable", i), key_stable, vecs[i].exp_key);
    end

    // Auto-repeat on key 1, then a direct switch to key 4 that restarts the repeat count.
    apply_stimulus(16'h0002, 20);
    check_output("repeat_key_stable", key_stable, 4'h1);
    apply_stimulus(16'h0010, 14);
    check_output("switch_key_stable", key_stable, 4'h4);
    apply_stimulus(16'h0000, 6);

    // Key 0 bouncing for three scans, then held.
    apply_stimulus(16'h0001, 1);
    apply_stimulus(16'h0000, 1);
    apply_stimulus(16'h0001, 1);
    check_output("bounce_key_stable_early", key_stable, 4'hF);
    apply_stimulus(16'h0001, 6);
    check_output("bounce_key_stable", key_stable, 4'h0);
    apply_stimulus(16'h0000, 6);

    // Reset landing on a pulse cycle, then full debounce from scratch.
    apply_stimulus(16'h0002, 4);
    @(posedge clock);
    #1;
    check_output("pulse_before_reset", control, 4'b0001);
    #1 reset = 1'b0;
    #1;
    check_reset_values("mid_pulse");
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_cycle(1);
    apply_stimulus(16'h0002, 6);
    check_output("after_reset_key_stable", key_stable, 4'h1);
    apply_stimulus(16'h0000, 6);

    // Reset while row 2 is driven with an unmapped key stable.
    apply_stimulus(16'h0400, 6);
    check_output("unmapped_key_stable", key_stable, 4'hA);
    wait_cycle(cyc + 39);
    check_output("row2_before_reset", keypad_row, 4'b1011);
    #2 reset = 1'b0;
    #1;
    check_reset_values("mid_scan");
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_cycle(1);
    apply_stimulus(16'h0400, 3);
    check_output("redebounce_key_early", key_stable, 4'hF);
    apply_stimulus(16'h0400, 3);
    check_output("redebounce_key", key_stable, 4'hA);
    apply_stimulus(16'h0000, 2);

    check_output("pending_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_ctrl.md
# keypad_ctrl

Scans a 4x4 active-low key matrix, debounces it and turns the player's key presses into the 4-bit move codes the paddle stage acts on. It sits directly upstream of the paddle register: its `control` output drives the paddle's `control` input on the same `clock`. The paddle applies a move on every clock edge, so this block emits each move as a single-cycle code. The block holds the idle code 4'b1111 at all other times.

## Interface
Parameters:
- SCAN_DIV, 16: clocks each row is driven before its columns are sampled (≥2)
- DEBOUNCE, 4: consecutive identical full-matrix snapshots needed to accept a new key state (≥1)
- REPEAT, 8: full scans between auto-repeat pulses while a key is held (≥1)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low
- keypad_col  input  4  column lines, active-low (0 = key closed on the driven row)
- keypad_row  output  4  row drive, one-hot-low
- control  output  4  move code to paddle; 4'b1111 = hold
- key_stable  output  4  debounced decoded key index, 4'hF = none/invalid
- scan_done  output  1  one-clock pulse on completion of each full 4-row scan

## Operation
- Row scan:
  - The row index r cycles 0→1→2→3→0.
  - keypad_row = ~(4'b0001 << r).
  - A divide counter counts 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, ~keypad_col is captured into snapshot bits [4r+3:4r], then r advances.
- Snapshot complete after row 3 is captured:
  - scan_done pulses for one clock.
  - The debounce logic runs: if the snapshot equals the previous snapshot, the match counter increments, saturating at DEBOUNCE. Otherwise the match counter resets to 1 and the previous snapshot is updated.
  - When the match counter reaches DEBOUNCE, the snapshot becomes the stable state.
- Decode of the stable state: exactly one key closed → key_stable = its index (4r+c). Zero keys or two or more keys → 4'hF.
- Move map:
  - index 0 → 4'b0100 (left 1)
  - index 1 → 4'b0001 (right 1)
  - index 4 → 4'b0110 (left 2)
  - index 5 → 4'b0011 (right 2)
  - all other indices and 4'hF → no move
- Pulse FSM (IDLE, HELD):
  - IDLE: on a stable change to a mapped index → control = code for exactly one clock, repeat counter = 0, go to HELD.
  - HELD: each scan_done increments the repeat counter. When it reaches REPEAT, emit a one-clock pulse and clear the counter.
  - HELD: a stable change to a different mapped index → immediate one-clock pulse of the new code, counter cleared.
  - HELD: a stable change to an unmapped index or none → IDLE, no pulse.
- control = 4'b1111 on every clock that does not carry a pulse. Pulses never occur on two consecutive clocks.

## Timing
Reset values (asynchronous, active-low):
- keypad_row = 4'b1110
- control = 4'b1111
- key_stable = 4'hF
- scan_done = 0
- all counters = 0
- previous and stable snapshots = 0
- FSM = IDLE

Cycle-level behaviour:
- One full scan takes 4·SCAN_DIV clocks.
- scan_done is registered and asserts the clock after row 3's capture edge.
- key_stable updates on the same edge as scan_done asserts.
- The first pulse appears one clock after key_stable changes, and lasts 1 clock.
- Press-to-pulse latency, for a key closed before the first capture of a scan: DEBOUNCE full scans plus 2 clocks, i.e. 258 clocks with defaults.
- Auto-repeat period: REPEAT·4·SCAN_DIV clocks, i.e. 512 with defaults.
- Reset asserted mid-scan or mid-pulse: all state returns to reset values immediately. After release, scanning restarts at row 0, count 0, and a held key requires full debounce again.
- A snapshot differing in any bit, including a bounce on an unmapped key, restarts debounce.

## Test plan
- Reset: pull reset low mid-scan → keypad_row=4'b1110, control=4'b1111, key_stable=4'hF asynchronously. Release → the first scan_done arrives 65 clocks later.
- Single press: hold key 1 (row0/col1 low when row0 driven) → exactly one control=4'b0001 pulse at 258 clocks. Pulses repeat every 512 clocks while held. After release, control stays 4'b1111.
- Bounce: toggle key 0 every scan for 3 scans, then hold it → no pulse until 4 identical scans. Then one 4'b0100 pulse.
- Two keys: hold keys 4 and 5 together → key_stable=4'hF, control never leaves 4'b1111.
- Direct switch: hold key 5 (4'b0011 pulse), then move to key 4 without a release gap → a 4'b0110 pulse once debounced, with the repeat counter restarted.
- Unmapped key: hold key 10 → key_stable=4'hA, no pulse, FSM stays IDLE.
